// File: rtl/mx_arb_pkg.sv
// Shared types and constants for the MX11 read-channel arbiter.
// Grant encodings are one-hot, so gnt[1] doubles as "m1 owns the bus".
package mx_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // The watchdog must be able to hold TIMEOUT_CYCLES so that it can saturate there.
  function automatic int wdog_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mx_arb_pick.sv
// Combinational two-requester picker producing a one-hot winner.
// With MX_ARB_RR_EN defined a tie goes to the master that did not own last; otherwise m1 wins.
module mx_arb_pick
  import mx_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] win_o
);

`ifdef MX_ARB_RR_EN
  always_comb begin
    win_o = GNT_NONE;
    if (&req_i) begin
      win_o = last_i ? GNT_M0 : GNT_M1;
    end else if (req_i[1]) begin
      win_o = GNT_M1;
    end else if (req_i[0]) begin
      win_o = GNT_M0;
    end
  end
`else
  logic unusedLast;
  assign unusedLast = last_i;

  always_comb begin
    win_o = GNT_NONE;
    if (req_i[1]) begin
      win_o = GNT_M1;
    end else if (req_i[0]) begin
      win_o = GNT_M0;
    end
  end
`endif

endmodule

// File: rtl/mx11_rd_arbiter.sv
// MX bus read-channel arbiter: fetch (m0) and data (m1) masters share one slave per transaction.
// Build option MX_ARB_RR_EN selects round-robin tie-breaking instead of fixed m1-over-m0 priority.
module mx11_rd_arbiter
  import mx_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_rd_txn_start,
  input  logic [ADDR_WIDTH-1:0] m0_rd_addr,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  output logic                  m0_rd_ready,
  output logic                  m0_rd_txn_ack,
  output logic                  m0_rd_txn_cpl,
  input  logic                  m1_rd_txn_start,
  input  logic [ADDR_WIDTH-1:0] m1_rd_addr,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic                  m1_rd_ready,
  output logic                  m1_rd_txn_ack,
  output logic                  m1_rd_txn_cpl,
  output logic                  s_rd_txn_start,
  output logic [ADDR_WIDTH-1:0] s_rd_addr,
  input  logic [DATA_WIDTH-1:0] s_rd_data,
  input  logic                  s_rd_ready,
  input  logic                  s_rd_txn_ack,
  input  logic                  s_rd_txn_cpl,
  output logic [1:0]            gnt,
  output logic                  timeout_err
);

  localparam int               WdogW    = wdog_width(TIMEOUT_CYCLES);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);
  localparam logic [WdogW-1:0] WdogMax  = {WdogW{1'b1}};

  arb_state_t       state_q;
  logic [1:0]       gnt_q;
  logic [WdogW-1:0] wdog_q;
  logic             acked_q;
  logic             lastM1;
  logic [1:0]       req;
  logic [1:0]       win;
  logic             own;
  logic             own0;
  logic             own1;
  logic             ownerStart;
  logic             abandon;
  logic             timeout;

`ifdef MX_ARB_RR_EN
  logic last_q;
  assign lastM1 = last_q;
`else
  assign lastM1 = 1'b1;
`endif

  assign req = {m1_rd_txn_start, m0_rd_txn_start};

  mx_arb_pick uPick (
    .req_i (req),
    .last_i(lastM1),
    .win_o (win)
  );

  assign own        = (state_q == ARB_OWN);
  assign own0       = own & gnt_q[0];
  assign own1       = own & gnt_q[1];
  assign ownerStart = gnt_q[1] ? m1_rd_txn_start : m0_rd_txn_start;

  // A real completion always beats both an abandon and a watchdog expiry in the same cycle.
  assign abandon = own & ~acked_q & ~ownerStart & ~s_rd_txn_cpl;
  assign timeout = own & ~s_rd_txn_cpl & ~abandon & (wdog_q == WdogLast);

  assign s_rd_txn_start = own & ~acked_q & ownerStart;
  assign s_rd_addr      = own ? (gnt_q[1] ? m1_rd_addr : m0_rd_addr) : '0;
  assign gnt            = gnt_q;
  assign timeout_err    = timeout;

  assign m0_rd_data    = own0 ? s_rd_data : '0;
  assign m0_rd_ready   = own0 & s_rd_ready;
  assign m0_rd_txn_ack = own0 & s_rd_txn_ack;
  assign m0_rd_txn_cpl = own0 & (s_rd_txn_cpl | timeout);

  assign m1_rd_data    = own1 ? s_rd_data : '0;
  assign m1_rd_ready   = own1 & s_rd_ready;
  assign m1_rd_txn_ack = own1 & s_rd_txn_ack;
  assign m1_rd_txn_cpl = own1 & (s_rd_txn_cpl | timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= GNT_NONE;
      wdog_q  <= '0;
      acked_q <= 1'b0;
`ifdef MX_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|req) begin
            state_q <= ARB_OWN;
            gnt_q   <= win;
            wdog_q  <= '0;
            acked_q <= 1'b0;
          end
        end
        ARB_OWN: begin
          if (s_rd_txn_cpl || timeout) begin
            state_q <= ARB_IDLE;
            gnt_q   <= GNT_NONE;
`ifdef MX_ARB_RR_EN
            last_q  <= gnt_q[1];
`endif
          end else if (abandon) begin
            state_q <= ARB_IDLE;
            gnt_q   <= GNT_NONE;
          end else begin
            if (wdog_q != WdogMax) begin
              wdog_q <= wdog_q + WdogW'(1);
            end
            if (s_rd_txn_ack) begin
              acked_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          gnt_q   <= GNT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mx11_rd_arbiter.sv
// Self-checking bench for mx11_rd_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of owner, ack and elapsed cycles.
module tb_mx11_rd_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          clk;
  logic          rst;
  logic          m0Start, m1Start;
  logic [AW-1:0] m0Addr, m1Addr;
  logic [DW-1:0] m0Data, m1Data;
  logic          m0Ready, m1Ready, m0Ack, m1Ack, m0Cpl, m1Cpl;
  logic          sStart;
  logic [AW-1:0] sAddr;
  logic [DW-1:0] sData;
  logic          sReady, sAck, sCpl;
  logic [1:0]    gnt;
  logic          timeoutErr;

  int testsRun  = 0;
  int failCount = 0;

  // Model state: owner 0 = none, 1 = m0, 2 = m1; ownCycles counts completed OWN cycles.
  int owner     = 0;
  int ownCycles = 0;
  int lastOwner = 2;
  bit ackSeen   = 1'b0;

  logic [1:0]    expGnt;
  logic          expSStart;
  logic [AW-1:0] expSAddr;
  logic          expErr;
  logic [DW+2:0] expM0, expM1;
  bit            expiredNow, droppedNow;

  bit            m0Active, m1Active;

  mx11_rd_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m0_rd_txn_start(m0Start),
    .m0_rd_addr     (m0Addr),
    .m0_rd_data     (m0Data),
    .m0_rd_ready    (m0Ready),
    .m0_rd_txn_ack  (m0Ack),
    .m0_rd_txn_cpl  (m0Cpl),
    .m1_rd_txn_start(m1Start),
    .m1_rd_addr     (m1Addr),
    .m1_rd_data     (m1Data),
    .m1_rd_ready    (m1Ready),
    .m1_rd_txn_ack  (m1Ack),
    .m1_rd_txn_cpl  (m1Cpl),
    .s_rd_txn_start (sStart),
    .s_rd_addr      (sAddr),
    .s_rd_data      (sData),
    .s_rd_ready     (sReady),
    .s_rd_txn_ack   (sAck),
    .s_rd_txn_cpl   (sCpl),
    .gnt            (gnt),
    .timeout_err    (timeoutErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic m0s, input logic [AW-1:0] m0a,
                               input logic m1s, input logic [AW-1:0] m1a, input logic sa,
                               input logic sr, input logic [DW-1:0] sd, input logic sc);
    rst = r;
    m0Start = m0s; m0Addr = m0a;
    m1Start = m1s; m1Addr = m1a;
    sAck = sa; sReady = sr; sData = sd; sCpl = sc;
  endtask

  function automatic int pickWinner();
    if (m0Start && m1Start) begin
`ifdef MX_ARB_RR_EN
      return (lastOwner == 1) ? 2 : 1;
`else
      return 2;
`endif
    end
    return m1Start ? 2 : 1;
  endfunction

  task automatic predict();
    logic ownStart;
    logic [DW+2:0] bundle;
    expGnt    = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    expSStart = 1'b0;
    expSAddr  = '0;
    expErr    = 1'b0;
    expM0     = '0;
    expM1     = '0;
    expiredNow = 1'b0;
    droppedNow = 1'b0;
    if (owner != 0) begin
      ownStart   = (owner == 1) ? m0Start : m1Start;
      expSStart  = !ackSeen && ownStart;
      expSAddr   = (owner == 1) ? m0Addr : m1Addr;
      droppedNow = !ackSeen && !ownStart && !sCpl;
      expiredNow = !sCpl && !droppedNow && (ownCycles == TO - 1);
      expErr     = expiredNow;
      bundle     = {sData, sReady, sAck, sCpl || expiredNow};
      if (owner == 1) expM0 = bundle;
      else            expM1 = bundle;
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".gnt"},    32'(gnt),        32'(expGnt));
    check({tag, ".sStart"}, 32'(sStart),     32'(expSStart));
    check({tag, ".sAddr"},  32'(sAddr),      32'(expSAddr));
    check({tag, ".err"},    32'(timeoutErr), 32'(expErr));
    check({tag, ".m0"},     32'({m0Data, m0Ready, m0Ack, m0Cpl}), 32'(expM0));
    check({tag, ".m1"},     32'({m1Data, m1Ready, m1Ack, m1Cpl}), 32'(expM1));
  endtask

  task automatic advanceModel();
    if (rst) begin
      owner = 0; ownCycles = 0; ackSeen = 1'b0; lastOwner = 2;
    end else if (owner == 0) begin
      if (m0Start || m1Start) begin
        owner = pickWinner(); ownCycles = 0; ackSeen = 1'b0;
      end
    end else if (sCpl || expiredNow) begin
      lastOwner = owner; owner = 0;
    end else if (droppedNow) begin
      owner = 0;
    end else begin
      ownCycles++;
      if (sAck) ackSeen = 1'b1;
    end
  endtask

  task automatic settle(input string tag);
    #3;
    predict();
    checkOutput(tag);
  endtask

  task automatic tick();
    advanceModel();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state with idle inputs.
    applyStimulus(1'b0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
    settle("reset");
    check("reset.gntConst", 32'(gnt), 32'h0);
    tick();

    // Solo m0 transaction; completion lands exactly on the last watchdog cycle.
    applyStimulus(0, 1, 8'h3C, 0, 8'h00, 0, 0, 8'h00, 0); settle("solo.c0"); tick();
    applyStimulus(0, 1, 8'h3C, 0, 8'h00, 0, 0, 8'h00, 0); settle("solo.c1");
    check("solo.gnt01", 32'(gnt), 32'h1);
    check("solo.addr3C", 32'(sAddr), 32'h3C);
    tick();
    applyStimulus(0, 1, 8'h3C, 0, 8'h00, 1, 0, 8'h00, 0); settle("solo.c2"); tick();
    applyStimulus(0, 0, 8'h3C, 0, 8'h00, 0, 1, 8'hA5, 0); settle("solo.c3");
    check("solo.dataA5", 32'(m0Data), 32'hA5);
    check("solo.m1Data0", 32'(m1Data), 32'h0);
    tick();
    applyStimulus(0, 0, 8'h3C, 0, 8'h00, 0, 0, 8'h00, 1); settle("solo.c4");
    check("solo.cpl", 32'(m0Cpl), 32'h1);
    check("solo.noErr", 32'(timeoutErr), 32'h0);
    tick();
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); settle("solo.c5");
    check("solo.gnt00", 32'(gnt), 32'h0);
    tick();

    // Simultaneous requests: m1 first, one dead cycle, then m0.
    applyStimulus(0, 1, 8'h11, 1, 8'h22, 0, 0, 8'h00, 0); settle("tie.c0"); tick();
    applyStimulus(0, 1, 8'h11, 1, 8'h22, 1, 0, 8'h00, 0); settle("tie.c1");
    check("tie.gntM1", 32'(gnt), 32'h2);
    tick();
    applyStimulus(0, 1, 8'h11, 0, 8'h22, 0, 1, 8'h5A, 1); settle("tie.c2");
    check("tie.m1Cpl", 32'(m1Cpl), 32'h1);
    tick();
    applyStimulus(0, 1, 8'h11, 0, 8'h22, 0, 0, 8'h00, 0); settle("tie.dead");
    check("tie.dead00", 32'(gnt), 32'h0);
    tick();
    applyStimulus(0, 1, 8'h11, 0, 8'h22, 1, 0, 8'h00, 0); settle("tie.c4");
    check("tie.gntM0", 32'(gnt), 32'h1);
    tick();
    applyStimulus(0, 0, 8'h11, 0, 8'h22, 0, 0, 8'h00, 1); settle("tie.c5"); tick();

    // Repeated ties after reset: alternate under round-robin, always m1 otherwise.
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); settle("rr.rst"); tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 8'h40, 1, 8'h80, 0, 0, 8'h00, 0); settle("rr.req"); tick();
      applyStimulus(0, 1, 8'h40, 1, 8'h80, 1, 0, 8'h00, 0); settle("rr.own");
`ifdef MX_ARB_RR_EN
      check("rr.order", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
`else
      check("rr.order", 32'(gnt), 32'h2);
`endif
      tick();
      applyStimulus(0, 0, 8'h40, 0, 8'h80, 0, 0, 8'h00, 1); settle("rr.cpl"); tick();
      applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); settle("rr.idle"); tick();
    end

    // Stalled slave: watchdog fires on the fourth OWN cycle.
    applyStimulus(0, 1, 8'h77, 0, 8'h00, 0, 0, 8'h00, 0); settle("stall.c0"); tick();
    for (int i = 1; i <= 3; i++) begin
      settle("stall.wait");
      check("stall.noErr", 32'(timeoutErr), 32'h0);
      tick();
    end
    settle("stall.c4");
    check("stall.err", 32'(timeoutErr), 32'h1);
    check("stall.synCpl", 32'(m0Cpl), 32'h1);
    tick();
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); settle("stall.c5");
    check("stall.idle", 32'(gnt), 32'h0);
    tick();

    // m1 abandons before ack while m0 waits.
    applyStimulus(0, 0, 8'h00, 1, 8'h99, 0, 0, 8'h00, 0); settle("aban.c0"); tick();
    applyStimulus(0, 1, 8'h33, 1, 8'h99, 0, 0, 8'h00, 0); settle("aban.c1"); tick();
    applyStimulus(0, 1, 8'h33, 0, 8'h99, 0, 0, 8'h00, 0); settle("aban.c2");
    check("aban.noCpl", 32'(m1Cpl), 32'h0);
    tick();
    settle("aban.c3");
    check("aban.idle", 32'(gnt), 32'h0);
    tick();
    applyStimulus(0, 1, 8'h33, 0, 8'h00, 1, 0, 8'h00, 0); settle("aban.c4");
    check("aban.gntM0", 32'(gnt), 32'h1);
    tick();
    applyStimulus(0, 0, 8'h33, 0, 8'h00, 0, 0, 8'h00, 1); settle("aban.c5"); tick();

    // Reset while owning after ack.
    applyStimulus(0, 0, 8'h00, 1, 8'hC4, 0, 0, 8'h00, 0); settle("mrst.c0"); tick();
    applyStimulus(0, 0, 8'h00, 1, 8'hC4, 1, 0, 8'h00, 0); settle("mrst.c1"); tick();
    applyStimulus(1, 0, 8'h00, 1, 8'hC4, 0, 1, 8'hEE, 0); settle("mrst.c2"); tick();
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 1, 8'hEE, 1); settle("mrst.c3");
    check("mrst.gnt00", 32'(gnt), 32'h0);
    check("mrst.m1Zero", 32'({m1Data, m1Ready, m1Ack, m1Cpl}), 32'h0);
    tick();

    // Random traffic; masters hold start until they see completion.
    m0Active = 1'b0;
    m1Active = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!m0Active && ($urandom % 3 == 0)) begin
        m0Active = 1'b1; m0Addr = AW'($urandom);
      end
      if (!m1Active && ($urandom % 3 == 0)) begin
        m1Active = 1'b1; m1Addr = AW'($urandom);
      end
      rst     = ($urandom % 97 == 0);
      m0Start = m0Active;
      m1Start = m1Active;
      sAck    = ($urandom % 4 == 0);
      sReady  = ($urandom % 3 == 0);
      sCpl    = ($urandom % 5 == 0);
      sData   = DW'($urandom);
      settle("rand");
      if (expM0[0]) m0Active = 1'b0;
      if (expM1[0]) m1Active = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/mx11_rd_arbiter.md
Name: mx11_rd_arbiter

Overview:
Two-master to one-slave arbiter for the MX bus read channel. It lets the instruction-fetch read master (m0) and the data read master (m1) share a single unified memory read port (s).
- Grants ownership for one whole transaction, from txn_start through txn_cpl.
- Forwards the slave handshake only to the owner.
- Aborts transactions that stall, using a watchdog.
- Sits between the MX11 core's ins_rd_*/data_rd_* ports and the memory-side MX bus.

Parameters:
ADDR_WIDTH, 8, read address width
DATA_WIDTH, 8, read data width
TIMEOUT_CYCLES, 255, cycles in OWN before watchdog abort; legal range 2..65535

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_rd_txn_start  in  1  fetch master request; held until ack
m0_rd_addr  in  ADDR_WIDTH  fetch master address
m0_rd_data  out  DATA_WIDTH  read data to m0
m0_rd_ready  out  1  data-valid strobe to m0
m0_rd_txn_ack  out  1  accept to m0
m0_rd_txn_cpl  out  1  completion to m0
m1_rd_txn_start, m1_rd_addr, m1_rd_data, m1_rd_ready, m1_rd_txn_ack, m1_rd_txn_cpl  same as m0, for the data master
s_rd_txn_start  out  1  request to slave
s_rd_addr  out  ADDR_WIDTH  address to slave
s_rd_data  in  DATA_WIDTH  slave read data
s_rd_ready  in  1  slave data-valid
s_rd_txn_ack  in  1  slave accept
s_rd_txn_cpl  in  1  slave completion
gnt  out  2  one-hot current owner; 00 when idle
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: state IDLE, gnt 00, s_rd_txn_start 0, s_rd_addr 0, timeout_err 0, all m*_ outputs 0, wdog 0, acked 0, last 1 (so m0 wins the first tie).
- States are IDLE and OWN.
- IDLE:
  - If any mN_rd_txn_start is high, pick a winner, register gnt, clear wdog and acked, and go to OWN.
  - Latency: request in cycle N gives gnt and s_rd_txn_start in cycle N+1.
  - s_* outputs are 0 in IDLE.
- OWN:
  - Address path: s_rd_txn_start equals the owner's txn_start while acked=0, then 0 after ack. s_rd_addr equals the owner's addr, combinational pass-through.
  - Response path: s_rd_data, ready, ack and cpl are routed combinationally to the owner only. The non-owner sees all zeros, including data.
  - s_rd_txn_ack sets acked. After ack, the owner's txn_start level is ignored.
  - s_rd_txn_cpl: cpl is forwarded the same cycle; next state IDLE, gnt 00, last = owner. Exactly one dead cycle follows before the next grant.
  - Owner drops txn_start before ack: abandon and go to IDLE next cycle. No cpl is forwarded; last is not updated.
  - Watchdog: wdog increments every OWN cycle and saturates.
    - When wdog == TIMEOUT_CYCLES-1 and no cpl arrives that cycle, pulse timeout_err.
    - In the same cycle, drive a synthetic txn_cpl to the owner, then go to IDLE with last = owner.
    - cpl and timeout in the same cycle: cpl wins, no err.
- s_rd_ready, ack or cpl arriving in IDLE: ignored, not forwarded, no error.
- Arbitration (default build): fixed priority, m1 (data) over m0 (fetch).
- Mid-operation rst: return to IDLE in the next cycle, drop s_rd_txn_start, no cpl to the owner.

Optional Feature:
MX_ARB_RR_EN
- Defined: round-robin arbitration. On a simultaneous request the winner is the master not equal to last. A single requester always wins.
- Undefined: the last register is not implemented and fixed m1-over-m0 priority applies.
- All other behaviour is identical in both builds.

Decomposition:
- Package mx_arb_pkg holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_OWN};
  - localparams GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10;
  - wdog width derived as $clog2(TIMEOUT_CYCLES+1).
- One sub-module, mx_arb_pick: combinational 2-requester picker. Inputs are req[1:0] and last; output is a one-hot win[1:0]. The round-robin mode is selected by MX_ARB_RR_EN.
- The FSM, watchdog and routing muxes stay in the top module.

Test Plan:
- Solo m0: m0 start, addr 8'h3C; slave acks at +2, ready with data 8'hA5 at +3, cpl at +4. Expect:
  - s_rd_addr = 3C from cycle N+1;
  - m0 sees data A5 and ready at +3;
  - m1 outputs stay 0;
  - gnt 01, then 00 after cpl.
- Simultaneous m0 and m1 from reset, default build: expect m1 granted first. After cpl and the one dead cycle, m0 is granted.
- Simultaneous requests repeated 4 times with MX_ARB_RR_EN defined: grant order is m0, m1, m0, m1.
- Stalled slave, TIMEOUT_CYCLES=4: no ack. Expect at the 4th OWN cycle a timeout_err pulse plus a synthetic cpl to the owner, followed by IDLE.
- m1 drops start before ack: expect IDLE next cycle, no cpl, m0 pending is granted the following cycle. rst asserted in OWN after ack: expect all outputs 0 and gnt 00 on the next edge.
